// File: rtl/sa_skew_feeder.sv
// Row-to-diagonal skew feeder for the processor_AB array: lane j re-emits element j of each accepted row j+1 cycles after accept.
// Latency 1+j cycles on lane j; in_ready drops for N cycles while the skew drains, FEED-cycle gaps travel as bubbles.
module sa_skew_feeder #(
    parameter int GF_BIT      = 4,
    parameter int N           = 8,
    parameter int OP_CODE_LEN = 4,
    parameter int ROW_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROW_W-1:0]           cfg_rows,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*GF_BIT-1:0]        in_data,
    input  logic [OP_CODE_LEN-1:0]     in_op,
    input  logic [1:0]                 in_gauss_op,
    output logic [N-1:0]               lane_valid,
    output logic [N*GF_BIT-1:0]        data_out,
    output logic [N*OP_CODE_LEN-1:0]   op_out,
    output logic [N*2-1:0]             gauss_op_out,
    output logic [N-1:0]               start_out,
    output logic [N-1:0]               finish_out,
    output logic                       busy,
    output logic                       done
);

    localparam int DCW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic                   valid;
        logic [GF_BIT-1:0]      data;
        logic [OP_CODE_LEN-1:0] op;
        logic [1:0]             gauss_op;
        logic                   start;
        logic                   finish;
    } beat_t;

    logic [1:0]             state;
    logic [ROW_W-1:0]       rows;
    logic [ROW_W-1:0]       row_cnt;
    logic [DCW-1:0]         drain_cnt;
    logic [OP_CODE_LEN-1:0] op_hold;

    logic                   accept;
    logic                   first_row;
    logic                   last_row;
    logic [OP_CODE_LEN-1:0] beat_op;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE:  in_ready = (cfg_rows != '0);
            S_FEED:  in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign first_row = (state == S_IDLE);
    // In IDLE the row count is not latched yet, so a single-row matrix is seen on cfg_rows directly.
    assign last_row  = first_row ? (cfg_rows == ROW_W'(1))
                                 : (row_cnt == rows - ROW_W'(1));
    assign beat_op   = accept ? in_op : op_hold;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rows      <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            op_hold   <= '0;
            done      <= 1'b0;
        end else begin
            if (accept)
                op_hold <= in_op;
            // Registered so the pulse lands with the last lane's finish flag.
            done <= (state == S_DRAIN) && (drain_cnt == DCW'(N - 2));
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rows      <= cfg_rows;
                        row_cnt   <= ROW_W'(1);
                        drain_cnt <= '0;
                        state     <= last_row ? S_DRAIN : S_FEED;
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (last_row) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DCW'(N - 1))
                        state <= S_IDLE;
                    else
                        drain_cnt <= drain_cnt + DCW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        beat_t head;
        beat_t chain [0:j];

        // Non-accept cycles inject a pass beat carrying the last op so downstream sees a stable tag.
        always_comb begin
            head    = '0;
            head.op = beat_op;
            if (accept) begin
                head.valid    = 1'b1;
                head.data     = in_data[j*GF_BIT +: GF_BIT];
                head.gauss_op = in_gauss_op;
                head.start    = first_row;
                head.finish   = last_row;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= j; s++)
                    chain[s] <= '0;
            end else begin
                chain[0] <= head;
                for (int s = 1; s <= j; s++)
                    chain[s] <= chain[s-1];
            end
        end

        assign lane_valid[j]                          = chain[j].valid;
        assign data_out[j*GF_BIT +: GF_BIT]           = chain[j].data;
        assign op_out[j*OP_CODE_LEN +: OP_CODE_LEN]   = chain[j].op;
        assign gauss_op_out[j*2 +: 2]                 = chain[j].gauss_op;
        assign start_out[j]                           = chain[j].start;
        assign finish_out[j]                          = chain[j].finish;
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder (N=4, GF_BIT=4): per-cycle vector table plus a cfg-change sequence.
module tb_sa_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_rows;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_op;
    logic [1:0]  in_gauss_op;
    logic [3:0]  lane_valid;
    logic [15:0] data_out;
    logic [15:0] op_out;
    logic [7:0]  gauss_op_out;
    logic [3:0]  start_out;
    logic [3:0]  finish_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_skew_feeder #(.GF_BIT(4), .N(4), .OP_CODE_LEN(4), .ROW_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_rows     (cfg_rows),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_op        (in_op),
        .in_gauss_op  (in_gauss_op),
        .lane_valid   (lane_valid),
        .data_out     (data_out),
        .op_out       (op_out),
        .gauss_op_out (gauss_op_out),
        .start_out    (start_out),
        .finish_out   (finish_out),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic        chk;
        logic        rst;
        logic [7:0]  cfg;
        logic        vld;
        logic [15:0] dat;
        logic [3:0]  op;
        logic [1:0]  gop;
        logic        e_rdy;
        logic [3:0]  e_lv;
        logic [15:0] e_dat;
        logic [15:0] e_op;
        logic [7:0]  e_gop;
        logic [3:0]  e_st;
        logic [3:0]  e_fi;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic chk, input logic r, input logic [7:0] cfg, input logic vld,
                       input logic [15:0] dat, input logic [3:0] op, input logic [1:0] gop,
                       input logic e_rdy, input logic [3:0] e_lv, input logic [15:0] e_dat,
                       input logic [15:0] e_op, input logic [7:0] e_gop, input logic [3:0] e_st,
                       input logic [3:0] e_fi, input logic e_done, input logic e_busy);
        vec_t v;
        v.chk = chk; v.rst = r; v.cfg = cfg; v.vld = vld; v.dat = dat; v.op = op; v.gop = gop;
        v.e_rdy = e_rdy; v.e_lv = e_lv; v.e_dat = e_dat; v.e_op = e_op; v.e_gop = e_gop;
        v.e_st = e_st; v.e_fi = e_fi; v.e_done = e_done; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec=%0d %s actual=%0h expected=%0h", idx, name, act, exp);
        end
    endtask

    task automatic reset_row();
        add(0, 1, 8'd3, 0, 'h0, 'h0, 2'd0, 0, 'h0, 'h0, 'h0, 'h0, 'h0, 'h0, 0, 0);
    endtask

    initial begin
        int acc_cnt;
        int lv0_cnt;
        int fin_idx;
        int done_seen;
        int fin3_at_done;

        rst = 1'b1; cfg_rows = 8'd3; in_valid = 1'b0; in_data = '0; in_op = '0; in_gauss_op = '0;

        // Idle after reset: ready follows cfg_rows, nothing accepted while cfg_rows==0.
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd0, 1, 'h1234, 'h0, 2'd0, 0, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd0, 0, 'h0000, 'h0, 2'd0, 0, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        reset_row();
        // Three back-to-back rows; blocked beats during drain carry a different op/gauss_op.
        add(1, 0, 8'd3, 1, 'h4321, 'hA, 2'd1, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd3, 1, 'h8765, 'hA, 2'd1, 1, 'h1, 'h0001, 'h000A, 'h01, 'h1, 'h0, 0, 1);
        add(1, 0, 8'd3, 1, 'hCBA9, 'hA, 2'd1, 1, 'h3, 'h0025, 'h00AA, 'h05, 'h2, 'h0, 0, 1);
        add(1, 0, 8'd3, 1, 'hFFFF, 'hF, 2'd3, 0, 'h7, 'h0369, 'h0AAA, 'h15, 'h4, 'h1, 0, 1);
        add(1, 0, 8'd3, 1, 'hFFFF, 'hF, 2'd3, 0, 'hE, 'h47A0, 'hAAAA, 'h54, 'h8, 'h2, 0, 1);
        add(1, 0, 8'd3, 1, 'hFFFF, 'hF, 2'd3, 0, 'hC, 'h8B00, 'hAAAA, 'h50, 'h0, 'h4, 0, 1);
        add(1, 0, 8'd3, 1, 'hFFFF, 'hF, 2'd3, 0, 'h8, 'hC000, 'hAAAA, 'h40, 'h0, 'h8, 1, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 1, 'h0, 'h0000, 'hAAAA, 'h00, 'h0, 'h0, 0, 0);
        reset_row();
        // Same rows with a gap after row 0: one bubble slot per lane.
        add(1, 0, 8'd3, 1, 'h4321, 'hA, 2'd1, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 1, 'h1, 'h0001, 'h000A, 'h01, 'h1, 'h0, 0, 1);
        add(1, 0, 8'd3, 1, 'h8765, 'hA, 2'd1, 1, 'h2, 'h0020, 'h00AA, 'h04, 'h2, 'h0, 0, 1);
        add(1, 0, 8'd3, 1, 'hCBA9, 'hA, 2'd1, 1, 'h5, 'h0305, 'h0AAA, 'h11, 'h4, 'h0, 0, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 0, 'hB, 'h4069, 'hAAAA, 'h45, 'h8, 'h1, 0, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 0, 'h6, 'h07A0, 'hAAAA, 'h14, 'h0, 'h2, 0, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 0, 'hC, 'h8B00, 'hAAAA, 'h50, 'h0, 'h4, 0, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 0, 'h8, 'hC000, 'hAAAA, 'h40, 'h0, 'h8, 1, 1);
        add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 1, 'h0, 'h0000, 'hAAAA, 'h00, 'h0, 'h0, 0, 0);
        reset_row();
        // Single-row matrix: start and finish together on every lane.
        add(1, 0, 8'd1, 1, 'h0F0F, 'h5, 2'd2, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd1, 0, 'h0000, 'h0, 2'd0, 0, 'h1, 'h000F, 'h0005, 'h02, 'h1, 'h1, 0, 1);
        add(1, 0, 8'd1, 0, 'h0000, 'h0, 2'd0, 0, 'h2, 'h0000, 'h0055, 'h08, 'h2, 'h2, 0, 1);
        add(1, 0, 8'd1, 0, 'h0000, 'h0, 2'd0, 0, 'h4, 'h0F00, 'h0555, 'h20, 'h4, 'h4, 0, 1);
        add(1, 0, 8'd1, 0, 'h0000, 'h0, 2'd0, 0, 'h8, 'h0000, 'h5555, 'h80, 'h8, 'h8, 1, 1);
        add(1, 0, 8'd1, 0, 'h0000, 'h0, 2'd0, 1, 'h0, 'h0000, 'h5555, 'h00, 'h0, 'h0, 0, 0);
        reset_row();
        // Reset asserted in cycle 2 of the three-row matrix: everything discarded, no done.
        add(1, 0, 8'd3, 1, 'h4321, 'hA, 2'd1, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);
        add(1, 0, 8'd3, 1, 'h8765, 'hA, 2'd1, 1, 'h1, 'h0001, 'h000A, 'h01, 'h1, 'h0, 0, 1);
        add(1, 1, 8'd3, 1, 'hCBA9, 'hA, 2'd1, 1, 'h3, 'h0025, 'h00AA, 'h05, 'h2, 'h0, 0, 1);
        for (int k = 0; k < 5; k++)
            add(1, 0, 8'd3, 0, 'h0000, 'h0, 2'd0, 1, 'h0, 'h0000, 'h0000, 'h00, 'h0, 'h0, 0, 0);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; cfg_rows = vecs[i].cfg; in_valid = vecs[i].vld;
            in_data = vecs[i].dat; in_op = vecs[i].op; in_gauss_op = vecs[i].gop;
            @(negedge clk);
            if (vecs[i].chk) begin
                cmp("in_ready",     i, in_ready,     vecs[i].e_rdy);
                cmp("lane_valid",   i, lane_valid,   vecs[i].e_lv);
                cmp("data_out",     i, data_out,     vecs[i].e_dat);
                cmp("op_out",       i, op_out,       vecs[i].e_op);
                cmp("gauss_op_out", i, gauss_op_out, vecs[i].e_gop);
                cmp("start_out",    i, start_out,    vecs[i].e_st);
                cmp("finish_out",   i, finish_out,   vecs[i].e_fi);
                cmp("done",         i, done,         vecs[i].e_done);
                cmp("busy",         i, busy,         vecs[i].e_busy);
            end
            @(posedge clk);
            #1;
        end

        // cfg_rows raised to 5 after the first accept must not extend the 3-row matrix.
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; cfg_rows = 8'd3; in_valid = 1'b1; in_data = 16'h1111; in_op = 4'h3; in_gauss_op = 2'd1;
        acc_cnt = 0; lv0_cnt = 0; fin_idx = 0; done_seen = 0; fin3_at_done = 0;
        for (int c = 0; c < 40 && done_seen == 0; c++) begin
            @(negedge clk);
            if (in_valid && in_ready)
                acc_cnt++;
            if (lane_valid[0]) begin
                lv0_cnt++;
                if (finish_out[0])
                    fin_idx = lv0_cnt;
            end
            if (done) begin
                done_seen = 1;
                fin3_at_done = int'(finish_out[3]);
            end
            @(posedge clk);
            #1;
            if (acc_cnt >= 1)
                cfg_rows = 8'd5;
            in_data = in_data + 16'h1111;
        end
        in_valid = 1'b0;
        cmp("cfg_chg_done_seen",   1000, done_seen,    1);
        cmp("cfg_chg_accepts",     1000, acc_cnt,      3);
        cmp("cfg_chg_lane0_beats", 1000, lv0_cnt,      3);
        cmp("cfg_chg_finish_idx",  1000, fin_idx,      3);
        cmp("cfg_chg_fin3_done",   1000, fin3_at_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
